uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that consumes the 16x `oversample_tick` from the baud generator. It deserializes an asynchronous serial line into parallel bytes. It resynchronizes the line, detects the start edge, and samples each bit at its centre. Received words go to the downstream FIFO/host logic as single-cycle valid pulses with framing-error and optional parity-error flags.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..8, sent LSB first.
- `PARITY_ODD`, 0: with the parity feature compiled in, 1 selects odd parity and 0 selects even. Ignored otherwise.
- `clk` input 1: system clock, the same clock that drives the baud generator.
- `reset` input 1: asynchronous, active-high reset.
- `os_tick` input 1: 16x oversample strobe, one `clk` wide.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `rx_data` output DATA_BITS: last received word. Holds its value until the next frame completes.
- `rx_valid` output 1: one-cycle pulse when a frame completes with a good stop bit.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `parity_err` output 1: one-cycle pulse coincident with `rx_valid` or `frame_err` when parity mismatches. Tied 0 without the parity feature.
- `busy` output 1: high in every state except IDLE.

## Operation
- Input synchronizer: 2-flop chain on `rx`, both flops reset to 1. A third flop holds the previous synchronized value for edge detection.
- State machine: IDLE, START, DATA, PARITY (only with the parity feature), STOP.
- Internal counters:
  - 4-bit tick counter `tcnt`, advanced only on `os_tick`.
  - Bit counter `bcnt`, width `$clog2(DATA_BITS)`.
  - Shift register of DATA_BITS.
- IDLE: a synchronized falling edge (prev=1, now=0) moves to START with `tcnt`=0. The edge check runs every `clk`, not only on ticks. A line held low never retriggers; only a high-to-low transition does.
- START: on the `os_tick` with `tcnt`=7 (mid start bit):
  - Line low: go to DATA with `tcnt`=0 and `bcnt`=0.
  - Line high: glitch, return to IDLE with no output pulse.
- DATA: on the `os_tick` with `tcnt`=15, sample the line and shift it into the MSB (right shift, so LSB-first order lands correctly). Increment `bcnt`. After bit DATA_BITS-1, go to PARITY if present, else STOP, with `tcnt`=0.
- PARITY: sample at `tcnt`=15 and compare against the XOR of the data, inverted when PARITY_ODD=1. Store the mismatch flag, then go to STOP.
- STOP: sample at `tcnt`=15.
  - Sample 1: load `rx_data` and pulse `rx_valid`.
  - Sample 0: load `rx_data` and pulse `frame_err`; `rx_valid` stays 0.
  - In both cases, pulse `parity_err` if the mismatch flag is set, then return to IDLE.
- Sampling accumulates 8+16k ticks from the start edge, so each sample lands mid-bit ±1 tick of edge-detect jitter.
- Arithmetic: `tcnt` wraps 15→0 naturally and is forced to 0 on every state transition.
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - State IDLE; all counters and the shift register 0; synchronizer flops 1.
- Reset mid-frame aborts immediately with no pulse. After release, a new start needs a fresh falling edge.
- A new start edge arriving while in STOP is ignored. The next frame is caught only if its falling edge occurs after return to IDLE. Back-to-back frames work because the stop sample happens at mid stop bit, half a bit before the next start edge.
- There is no backpressure. The consumer must capture `rx_data` on `rx_valid`, and the next frame overwrites it.

## Timing
- `rx` to synchronized value: 2 `clk` cycles. Falling-edge detect: 3rd cycle.
- `rx_valid`, `frame_err` and `parity_err` assert for exactly one `clk` in the cycle after the STOP-sampling `os_tick` edge. `rx_data` updates in that same cycle.
- Frame latency from the start edge to `rx_valid` is 8 + 16·(DATA_BITS + P + 1) `os_tick` periods plus at most 4 `clk`, where P = 1 with parity and 0 without.
- `busy` rises the cycle after edge detection and falls the same cycle the output pulse asserts.
- A 1-cycle `os_tick` pulse coincident with a state change counts toward the new state only from the following tick.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists, the frame carries a parity bit after the data, and `parity_err` is functional per PARITY_ODD.
  - Undefined: there is no PARITY state, the frame is start + DATA_BITS + stop, and `parity_err` is constant 0.

## Test plan
- Reset with `rx`=1, release, then send 0xA5 at 115200 baud (clk 50 MHz) → one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0, `busy` low afterwards.
- Three back-to-back frames 0x00, 0xFF, 0x3C with a single stop bit each → three `rx_valid` pulses in order with matching `rx_data` and no errors.
- Drive `rx` low for 4 ticks then high (glitch) → no pulses, state back to IDLE, and a following 0x55 frame is received correctly.
- Send 0x81 with the stop bit forced 0, then hold `rx` low for 2 bit times → exactly one `frame_err` pulse, `rx_data`=0x81, `rx_valid`=0, no retrigger while the line stays low.
- With `UART_RX_PARITY_EN` defined and PARITY_ODD=0:
  - Send 0x07 with parity bit 1 → `rx_valid` with `parity_err`=0.
  - Send 0x07 with parity bit 0 → `rx_valid` with `parity_err`=1.
- Assert `reset` midway through the data bits of 0xC3 → all outputs 0 immediately, no pulse. After release, 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-line and received-word signals for uart_rx; slave = receiver, master = line/tick driver and consumer
interface uart_rx_if #(parameter int DATA_BITS = 8);
   logic                 os_tick;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 parity_err;
   logic                 busy;
   modport slave (input os_tick, rx, output rx_data, rx_valid, frame_err, parity_err, busy);
   modport master (output os_tick, rx, input rx_data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; clk, reset (async high), bus (uart_rx_if.slave); UART_RX_PARITY_EN adds a parity bit
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input logic      clk,
   input logic      reset,
   uart_rx_if.slave bus
);
   localparam int BW = $clog2(DATA_BITS);
   typedef enum logic [2:0] {IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP} state_t;
   state_t               state_q, state_d;
   logic                 s1_q, s2_q, prev_q;
   logic [3:0]           tcnt_q, tcnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
   logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
   logic                 pflag_q, pflag_d;
   logic                 fall, mid, last;
   assign fall = prev_q & ~s2_q;
   assign mid  = bus.os_tick && tcnt_q == 4'd15;
   assign last = bcnt_q == BW'(DATA_BITS - 1);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {s1_q, s2_q, prev_q} <= 3'b111;
         state_q <= IDLE;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         pflag_q <= 1'b0;
      end else begin
         {s1_q, s2_q, prev_q} <= {bus.rx, s1_q, s2_q};
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         pflag_q <= pflag_d;
      end
   end
   always_comb begin
      state_d = state_q;
      tcnt_d  = bus.os_tick ? tcnt_q + 4'd1 : tcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      pflag_d = pflag_q;
      case (state_q)
         IDLE: if (fall) begin
            state_d = START;
            tcnt_d  = '0;
         end
         START: if (bus.os_tick && tcnt_q == 4'd7) begin
            state_d = s2_q ? IDLE : DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
            pflag_d = 1'b0;
         end
         DATA: if (mid) begin
            // right shift so the first (LSB) bit ends up in bit 0
            shift_d = {s2_q, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + BW'(1);
            if (last) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
               tcnt_d = '0;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (mid) begin
            pflag_d = s2_q ^ (^shift_q) ^ 1'(PARITY_ODD);
            state_d = STOP;
            tcnt_d  = '0;
         end
`endif
         STOP: if (mid) begin
            data_d  = shift_q;
            valid_d = s2_q;
            ferr_d  = ~s2_q;
            perr_d  = pflag_q;
            state_d = IDLE;
            tcnt_d  = '0;
         end
         default: state_d = IDLE;
      endcase
   end
`ifndef UART_RX_PARITY_EN
   logic unused_parity_odd;
   assign unused_parity_odd = 1'(PARITY_ODD);
`endif
   assign bus.rx_data    = data_q;
   assign bus.rx_valid   = valid_q;
   assign bus.frame_err  = ferr_q;
   assign bus.parity_err = perr_q;
   assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 50 MHz clk, 115200 baud (27 clk per tick, 432 clk per bit)
module tb_uart_rx;
   localparam int TICK = 27;
   localparam int BIT  = 16 * TICK;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int nchk = 0, nfail = 0;
   int vcnt = 0, fcnt = 0, pcnt = 0, pco = 0;
   logic [7:0] got [64];
   int vb, fb, pb, cb;
   uart_rx_if #(.DATA_BITS(8)) bus ();
   uart_rx #(.DATA_BITS(8), .PARITY_ODD(0)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #10 clk = ~clk;
   initial begin
      bus.os_tick = 1'b0;
      forever begin
         repeat (TICK - 1) @(negedge clk);
         bus.os_tick = 1'b1;
         @(negedge clk);
         bus.os_tick = 1'b0;
      end
   end
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rx_valid) begin
            got[vcnt % 64] = bus.rx_data;
            vcnt++;
         end
         if (bus.frame_err) fcnt++;
         if (bus.parity_err) pcnt++;
         if (bus.parity_err && bus.rx_valid) pco++;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic line(input logic v, input int n);
      bus.rx = v;
      repeat (n) @(negedge clk);
   endtask
   task automatic send(input logic [7:0] d, input logic stop, input logic par_bad);
      line(1'b0, BIT);
      for (int i = 0; i < 8; i++) line(d[i], BIT);
`ifdef UART_RX_PARITY_EN
      line((^d) ^ par_bad, BIT);
`else
      if (par_bad) line(1'b1, 0);
`endif
      line(stop, BIT);
   endtask
   task automatic snap();
      vb = vcnt;
      fb = fcnt;
      pb = pcnt;
      cb = pco;
   endtask
   initial begin
      bus.rx = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_rx_data", 32'(bus.rx_data), 0);
      chk("reset_rx_valid", 32'(bus.rx_valid), 0);
      chk("reset_frame_err", 32'(bus.frame_err), 0);
      chk("reset_parity_err", 32'(bus.parity_err), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      reset = 1'b0;
      line(1'b1, BIT);
      snap();
      send(8'hA5, 1'b1, 1'b0);
      chk("a5_valid_cnt", 32'(vcnt - vb), 1);
      chk("a5_data", 32'(got[vb % 64]), 32'hA5);
      chk("a5_ferr_cnt", 32'(fcnt - fb), 0);
      chk("a5_busy_after", 32'(bus.busy), 0);
      line(1'b1, BIT);
      snap();
      send(8'h00, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b0);
      send(8'h3C, 1'b1, 1'b0);
      chk("b2b_valid_cnt", 32'(vcnt - vb), 3);
      chk("b2b_data0", 32'(got[vb % 64]), 32'h00);
      chk("b2b_data1", 32'(got[(vb + 1) % 64]), 32'hFF);
      chk("b2b_data2", 32'(got[(vb + 2) % 64]), 32'h3C);
      chk("b2b_ferr_cnt", 32'(fcnt - fb), 0);
      chk("b2b_perr_cnt", 32'(pcnt - pb), 0);
      line(1'b1, BIT);
      snap();
      line(1'b0, 4 * TICK);
      line(1'b1, BIT);
      chk("glitch_busy", 32'(bus.busy), 0);
      chk("glitch_valid_cnt", 32'(vcnt - vb), 0);
      chk("glitch_ferr_cnt", 32'(fcnt - fb), 0);
      snap();
      send(8'h55, 1'b1, 1'b0);
      chk("post_glitch_valid_cnt", 32'(vcnt - vb), 1);
      chk("post_glitch_data", 32'(got[vb % 64]), 32'h55);
      line(1'b1, BIT);
      snap();
      send(8'h81, 1'b0, 1'b0);
      line(1'b0, 2 * BIT);
      chk("ferr_cnt", 32'(fcnt - fb), 1);
      chk("ferr_valid_cnt", 32'(vcnt - vb), 0);
      chk("ferr_rx_data", 32'(bus.rx_data), 32'h81);
      chk("ferr_no_retrigger_busy", 32'(bus.busy), 0);
      line(1'b1, 2 * BIT);
      chk("ferr_rise_busy", 32'(bus.busy), 0);
`ifdef UART_RX_PARITY_EN
      snap();
      send(8'h07, 1'b1, 1'b0);
      chk("par_good_valid_cnt", 32'(vcnt - vb), 1);
      chk("par_good_perr_cnt", 32'(pcnt - pb), 0);
      line(1'b1, BIT);
      snap();
      send(8'h07, 1'b1, 1'b1);
      chk("par_bad_valid_cnt", 32'(vcnt - vb), 1);
      chk("par_bad_perr_cnt", 32'(pcnt - pb), 1);
      chk("par_bad_coincident", 32'(pco - cb), 1);
      chk("par_bad_data", 32'(got[vb % 64]), 32'h07);
      line(1'b1, BIT);
`endif
      snap();
      line(1'b0, BIT);
      line(1'b1, BIT);
      line(1'b1, BIT);
      line(1'b0, BIT / 2);
      chk("c3_busy_mid", 32'(bus.busy), 1);
      bus.rx = 1'b1;
      reset = 1'b1;
      #1;
      chk("rst_mid_rx_data", 32'(bus.rx_data), 0);
      chk("rst_mid_rx_valid", 32'(bus.rx_valid), 0);
      chk("rst_mid_frame_err", 32'(bus.frame_err), 0);
      chk("rst_mid_parity_err", 32'(bus.parity_err), 0);
      chk("rst_mid_busy", 32'(bus.busy), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      line(1'b1, 2 * BIT);
      chk("rst_no_valid", 32'(vcnt - vb), 0);
      chk("rst_no_ferr", 32'(fcnt - fb), 0);
      snap();
      send(8'h5A, 1'b1, 1'b0);
      chk("post_rst_valid_cnt", 32'(vcnt - vb), 1);
      chk("post_rst_data", 32'(got[vb % 64]), 32'h5A);
      chk("post_rst_ferr_cnt", 32'(fcnt - fb), 0);
      line(1'b1, BIT);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
